// File: rtl/pc_predict_unit_pkg.sv
// Shared types and saturating-counter helpers for the PC predict unit.
`ifndef XLEN
`define XLEN 32
`endif

package pc_predict_unit_pkg;

    // Widest direction counter the helpers support; callers truncate to CTR_BITS.
    localparam int CTR_MAX_W = 8;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    // Weak-not-taken: MSB clear, every lower bit set.
    function automatic ctr_t ctr_weak_nt(input int w);
        return ctr_t'((1 << (w - 1)) - 1);
    endfunction

    // Weak-taken: MSB set, every lower bit clear.
    function automatic ctr_t ctr_weak_t(input int w);
        return ctr_t'(1 << (w - 1));
    endfunction

    // Increment that sticks at all-ones for a w-bit counter.
    function automatic ctr_t sat_inc(input ctr_t v, input int w);
        ctr_t mx;
        mx = ctr_t'((1 << w) - 1);
        return (v >= mx) ? mx : v + ctr_t'(1);
    endfunction

    // Decrement that sticks at zero.
    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/pc_predict_unit_btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// resolve read-modify-write) and a single write port committed at the edge.
module btb_array
    import pc_predict_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 26,
    parameter int CTR_BITS = 2,
    localparam int ENT_W   = 2 + TAG_W + XLEN + CTR_BITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic [ENT_W-1:0] rd_ent_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [ENT_W-1:0] rd_ent_b,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ENT_W-1:0] wr_ent
);

    localparam int   ENTRIES = 1 << IDX_W;
    localparam ctr_t CTR_NT  = ctr_weak_nt(CTR_BITS);

    typedef struct packed {
        logic                valid;
        logic                is_jump;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

    localparam btb_entry_t RST_ENT = '{valid: 1'b0, is_jump: 1'b0, tag: '0, target: '0,
                                       ctr: CTR_NT[CTR_BITS-1:0]};

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];

    assign rd_ent_a = mem_q[rd_idx_a];
    assign rd_ent_b = mem_q[rd_idx_b];

    // Apply at most one entry write per cycle.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = wr_ent;
    end

    // Reset empties the table and parks every counter at weak-not-taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) mem_q[i] <= RST_ENT;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register, BTB prediction and redirect arbitration. Late C-stage
// corrections outrank R-stage jumps, which outrank stall and prediction.
module pc_predict_unit
    import pc_predict_unit_pkg::*;
#(
    parameter int              XLEN         = `XLEN,
    parameter int              BTB_ENTRIES  = 16,
    parameter int              CTR_BITS     = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            Stall_I,
    output logic [XLEN-1:0] PC_I,
    output logic            PredictTaken_I,
    output logic [XLEN-1:0] PredictTarget_I,
    input  logic            JumpValid_R,
    input  logic            PredictTaken_R,
    input  logic [XLEN-1:0] PCpImm_R,
    input  logic            ResolveValid_C,
    input  logic            IsJump_C,
    input  logic            Taken_C,
    input  logic [XLEN-1:0] Target_C,
    input  logic [XLEN-1:0] PC_C,
    input  logic            PredictTaken_C,
    input  logic [XLEN-1:0] PredictTarget_C,
    output logic            FlushIR,
    output logic            FlushRC
);

    localparam int   IDX_W  = $clog2(BTB_ENTRIES);
    localparam int   TAG_W  = XLEN - IDX_W - 2;
    localparam ctr_t CTR_WT = ctr_weak_t(CTR_BITS);

    typedef struct packed {
        logic                valid;
        logic                is_jump;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

    logic [XLEN-1:0] pc_q, pc_d, npc;
    btb_entry_t      ent_i, ent_c, wr_ent;
    logic            wr_en, hit_i, hit_c, mispred_c, mispred_r;

    wire [IDX_W-1:0] idx_i = pc_q[IDX_W+1:2];
    wire [TAG_W-1:0] tag_i = pc_q[XLEN-1:IDX_W+2];
    wire [IDX_W-1:0] idx_c = PC_C[IDX_W+1:2];
    wire [TAG_W-1:0] tag_c = PC_C[XLEN-1:IDX_W+2];

    btb_array #(
        .XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_BITS(CTR_BITS)
    ) u_btb (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx_a (idx_i),
        .rd_ent_a (ent_i),
        .rd_idx_b (idx_c),
        .rd_ent_b (ent_c),
        .wr_en    (wr_en),
        .wr_idx   (idx_c),
        .wr_ent   (wr_ent)
    );

    // Lookup, mispredict detection and flushes; flushes are held low in reset.
    always_comb begin
        hit_i           = ent_i.valid && (ent_i.tag == tag_i);
        hit_c           = ent_c.valid && (ent_c.tag == tag_c);
        // ctr >= weak-taken is the same as "counter MSB set"
        PredictTaken_I  = hit_i && (ent_i.is_jump || (ent_i.ctr >= CTR_WT[CTR_BITS-1:0]));
        PredictTarget_I = ent_i.target;
        mispred_c       = ResolveValid_C && ((Taken_C != PredictTaken_C) ||
                                             (Taken_C && (Target_C != PredictTarget_C)));
        mispred_r       = JumpValid_R && !PredictTaken_R;
        FlushRC         = reset_n && mispred_c;
        FlushIR         = reset_n && (mispred_c || mispred_r);
    end

    // Next-PC priority mux; instruction fetch is always halfword aligned.
    always_comb begin
        if (mispred_c)           npc = Taken_C ? Target_C : PC_C + XLEN'(4);
        else if (mispred_r)      npc = PCpImm_R;
        else if (Stall_I)        npc = pc_q;
        else if (PredictTaken_I) npc = PredictTarget_I;
        else                     npc = pc_q + XLEN'(4);
        pc_d = {npc[XLEN-1:1], 1'b0};
    end

    // BTB training from the resolving C-stage branch; not-taken misses leave the table alone.
    always_comb begin
        wr_en  = 1'b0;
        wr_ent = ent_c;
        if (ResolveValid_C) begin
            if (hit_c) begin
                wr_en = 1'b1;
                if (Taken_C) begin
                    wr_ent.target  = Target_C;
                    wr_ent.is_jump = IsJump_C;
                    wr_ent.ctr     = CTR_BITS'(sat_inc(CTR_MAX_W'(ent_c.ctr), CTR_BITS));
                end else begin
                    wr_ent.ctr     = CTR_BITS'(sat_dec(CTR_MAX_W'(ent_c.ctr)));
                end
            end else if (Taken_C) begin
                wr_en  = 1'b1;
                wr_ent = '{valid: 1'b1, is_jump: IsJump_C, tag: tag_c, target: Target_C,
                           ctr: CTR_WT[CTR_BITS-1:0]};
            end
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_VECTOR;
        else          pc_q <= pc_d;
    end

    assign PC_I = pc_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Random + directed bench for pc_predict_unit against a table-level model.
module tb_pc_predict_unit;

    localparam int          XLEN = 32;
    localparam int          N    = 16;
    localparam int          CB   = 2;
    localparam int          IW   = 4;
    localparam logic [31:0] RV   = 32'h0;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        Stall_I = 0, JumpValid_R = 0, PredictTaken_R = 0;
    logic        ResolveValid_C = 0, IsJump_C = 0, Taken_C = 0, PredictTaken_C = 0;
    logic [31:0] PCpImm_R = 0, Target_C = 0, PC_C = 0, PredictTarget_C = 0;
    logic [31:0] PC_I, PredictTarget_I;
    logic        PredictTaken_I, FlushIR, FlushRC;

    int n_chk = 0, n_fail = 0;

    // reference model state
    bit          m_v   [N];
    bit          m_j   [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    logic [31:0] m_pc;

    pc_predict_unit #(.XLEN(XLEN), .BTB_ENTRIES(N), .CTR_BITS(CB), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset_n(reset_n), .Stall_I(Stall_I), .PC_I(PC_I),
        .PredictTaken_I(PredictTaken_I), .PredictTarget_I(PredictTarget_I),
        .JumpValid_R(JumpValid_R), .PredictTaken_R(PredictTaken_R), .PCpImm_R(PCpImm_R),
        .ResolveValid_C(ResolveValid_C), .IsJump_C(IsJump_C), .Taken_C(Taken_C),
        .Target_C(Target_C), .PC_C(PC_C), .PredictTaken_C(PredictTaken_C),
        .PredictTarget_C(PredictTarget_C), .FlushIR(FlushIR), .FlushRC(FlushRC));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / (4 * N));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_j[m_idx(pc)] || m_ctr[m_idx(pc)] >= 2 ** (CB - 1));
    endfunction

    task automatic m_reset();
        m_pc = RV;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_j[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
            m_ctr[i] = 2 ** (CB - 1) - 1;
        end
    endtask

    // One cycle: entered just after a falling edge, leaves at the next falling edge.
    task automatic step(input bit stall, input bit jv, input bit ptr, input logic [31:0] pcimm,
                        input bit rv, input bit isj, input bit tk, input logic [31:0] tgt,
                        input logic [31:0] pcc, input bit ptc, input logic [31:0] ptgtc);
        bit          pt, mc, mr;
        logic [31:0] nxt;
        int          i;
        Stall_I = stall; JumpValid_R = jv; PredictTaken_R = ptr; PCpImm_R = pcimm;
        ResolveValid_C = rv; IsJump_C = isj; Taken_C = tk; Target_C = tgt;
        PC_C = pcc; PredictTaken_C = ptc; PredictTarget_C = ptgtc;
        #1;
        pt = m_pred(m_pc);
        mc = rv && ((tk != ptc) || (tk && tgt != ptgtc));
        mr = jv && !ptr;
        chk("pc_i", PC_I, m_pc);
        chk("pred_taken_i", 32'(PredictTaken_I), 32'(pt));
        if (pt) chk("pred_target_i", PredictTarget_I, m_tgt[m_idx(m_pc)]);
        chk("flush_ir", 32'(FlushIR), 32'(mc || mr));
        chk("flush_rc", 32'(FlushRC), 32'(mc));
        if (mc)        nxt = tk ? tgt : pcc + 4;
        else if (mr)   nxt = pcimm;
        else if (stall) nxt = m_pc;
        else if (pt)   nxt = m_tgt[m_idx(m_pc)];
        else           nxt = m_pc + 4;
        m_pc = nxt & ~32'h1;
        i = m_idx(pcc);
        if (rv) begin
            if (m_hit(pcc)) begin
                if (tk) begin
                    m_tgt[i] = tgt; m_j[i] = isj;
                    m_ctr[i] = (m_ctr[i] + 1 > 2 ** CB - 1) ? 2 ** CB - 1 : m_ctr[i] + 1;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (tk) begin
                m_v[i] = 1; m_tag[i] = pcc / (4 * N); m_tgt[i] = tgt; m_j[i] = isj;
                m_ctr[i] = 2 ** (CB - 1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Redirect fetch to addr through an R-stage jump.
    task automatic goto(input logic [31:0] addr);
        step(0, 1, 0, addr, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Resolve a conditional branch whose carried prediction matches the model's belief.
    task automatic resolve(input logic [31:0] pcc, input bit tk, input logic [31:0] tgt);
        step(0, 0, 0, 0, 1, 0, tk, tgt, pcc, m_pred(pcc), m_tgt[m_idx(pcc)]);
    endtask

    task automatic random_step();
        bit          isj, tk, ptc;
        logic [31:0] pcc, tgt, ptg;
        pcc = 32'($urandom_range(0, 31)) * 4;
        tgt = 32'($urandom_range(0, 127)) * 4;
        if ($urandom_range(0, 7) == 0) tgt = tgt | 32'h1;
        isj = ($urandom_range(0, 7) == 0);
        tk  = isj ? 1'b1 : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) begin
            ptc = m_pred(pcc); ptg = m_tgt[m_idx(pcc)];
        end else begin
            ptc = 1'($urandom_range(0, 1)); ptg = 32'($urandom_range(0, 127)) * 4;
        end
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 127)) * 4, 1'($urandom_range(0, 1)), isj, tk, tgt, pcc, ptc, ptg);
    endtask

    initial begin
        m_reset();
        // reset held with a would-be mispredict on the inputs: flushes must stay low
        ResolveValid_C = 1; Taken_C = 1; PredictTaken_C = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", PC_I, RV);
        chk("rst_pred", 32'(PredictTaken_I), 0);
        chk("rst_flush_ir", 32'(FlushIR), 0);
        chk("rst_flush_rc", 32'(FlushRC), 0);
        @(negedge clk);
        reset_n = 1;

        repeat (4) idle();                       // sequential fetch 0,4,8,12
        chk("seq_pc", PC_I, 32'h10);

        // cold taken branch at 0x40 -> 0x100, then refetch 0x40
        step(0, 0, 0, 0, 1, 0, 1, 32'h100, 32'h40, 0, 0);
        chk("cold_pc", PC_I, 32'h100);
        goto(32'h40);
        #1;
        chk("cold_hit", 32'(PredictTaken_I), 1);
        chk("cold_tgt", PredictTarget_I, 32'h100);
        idle();

        // C mispredict (not taken at 0x80) beats R jump to 0x200
        step(0, 1, 0, 32'h200, 1, 0, 0, 0, 32'h80, 1, 0);
        chk("both_pc", PC_I, 32'h84);
        step(0, 1, 0, 32'h200, 1, 0, 0, 0, 32'h80, 0, 0);
        chk("r_only_pc", PC_I, 32'h200);

        // counter saturation at 0x40: 3 taken, 1 not-taken still predicts taken
        repeat (3) resolve(32'h40, 1, 32'h100);
        resolve(32'h40, 0, 0);
        goto(32'h40);
        #1 chk("sat_still_taken", 32'(PredictTaken_I), 1);
        idle();
        repeat (3) resolve(32'h40, 0, 0);        // down to zero and held there
        goto(32'h40);
        #1 chk("sat_not_taken", 32'(PredictTaken_I), 0);
        idle();
        resolve(32'h40, 1, 32'h100);             // from 0 one taken -> 1, still not taken
        goto(32'h40);
        idle();

        // alias 0x40 + 4*N replaces 0x40
        step(0, 0, 0, 0, 1, 0, 1, 32'h180, 32'h40 + 4 * N, 0, 0);
        goto(32'h40);
        #1 chk("alias_miss", 32'(PredictTaken_I), 0);
        idle();

        // stall does not block an R-stage redirect
        step(1, 1, 0, 32'h120, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_redirect", PC_I, 32'h120);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                reset_n = 0;
                ResolveValid_C = 1; Taken_C = 1; PredictTaken_C = 0;
                #1;
                m_reset();
                chk("midrst_pc", PC_I, RV);
                chk("midrst_pred", 32'(PredictTaken_I), 0);
                chk("midrst_flush", 32'({FlushIR, FlushRC}), 0);
                @(negedge clk);
                reset_n = 1;
            end
            random_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
